// File: rtl/contador_ctrl.sv
// Sequencer for the shared down-counter datapath: loads an iteration count, runs
// one req/ack handshake per iteration and flags a sticky error on ack timeout.
module contador_ctrl #(
  parameter int TW  = 4,
  parameter int TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       z,
  input  logic       ack,
  output logic [1:0] opc,
  output logic       req,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_REQ,
    S_DEC,
    S_DONE,
    S_ERR,
    S_ABT
  } state_t;

  localparam logic [1:0] OPC_CLR  = 2'd0;
  localparam logic [1:0] OPC_HOLD = 2'd1;
  localparam logic [1:0] OPC_DEC  = 2'd2;
  localparam logic [1:0] OPC_LOAD = 2'd3;

  localparam bit            TMO_EN   = (TMO != 0);
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TMO - 1) : '0;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Abort outranks every other condition in the active states, including ack.
  always_comb begin
    state_nx = state;
    tcnt_nx  = '0;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nx = S_LOAD;
      end
      S_LOAD: begin
        state_nx = abort ? S_ABT : S_CHECK;
      end
      S_CHECK: begin
        if (abort)  state_nx = S_ABT;
        else if (z) state_nx = S_DONE;
        else        state_nx = S_REQ;
      end
      S_REQ: begin
        if (abort)                            state_nx = S_ABT;
        else if (ack)                         state_nx = S_DEC;
        else if (TMO_EN && tcnt == TMO_LAST)  state_nx = S_ERR;
        else                                  tcnt_nx  = tcnt + 1'b1;
      end
      S_DEC: begin
        state_nx = abort ? S_ABT : S_CHECK;
      end
      S_DONE: begin
        state_nx = abort ? S_ABT : S_IDLE;
      end
      S_ERR: begin
        if (abort) state_nx = S_IDLE;
      end
      S_ABT: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Moore decode: outputs depend on the state register alone.
  always_comb begin
    opc  = OPC_HOLD;
    req  = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    err  = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_LOAD:  opc  = OPC_LOAD;
      S_CHECK: opc  = OPC_HOLD;
      S_REQ:   req  = 1'b1;
      S_DEC:   opc  = OPC_DEC;
      S_DONE:  done = 1'b1;
      S_ERR: begin
        opc = OPC_CLR;
        err = 1'b1;
      end
      S_ABT:   opc  = OPC_CLR;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_contador_ctrl.sv
// Scoreboard bench for contador_ctrl: per-cycle stimulus and expected output
// vectors are queued together, then replayed against a model of the counter.
module tb_contador_ctrl;

  localparam int TW  = 4;
  localparam int TMO = 15;

  // Expected {opc, req, busy, done, err} per state.
  localparam logic [5:0] V_IDLE = 6'b01_0_0_0_0;
  localparam logic [5:0] V_LOAD = 6'b11_0_1_0_0;
  localparam logic [5:0] V_CHK  = 6'b01_0_1_0_0;
  localparam logic [5:0] V_REQ  = 6'b01_1_1_0_0;
  localparam logic [5:0] V_DEC  = 6'b10_0_1_0_0;
  localparam logic [5:0] V_DONE = 6'b01_0_1_1_0;
  localparam logic [5:0] V_ERR  = 6'b00_0_1_0_1;
  localparam logic [5:0] V_ABT  = 6'b00_0_1_0_0;

  typedef struct packed {
    logic s;
    logic a;
    logic k;
  } stim_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ack   = 1'b0;
  logic       z;
  logic [1:0] opc;
  logic       req;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] cnt;
  logic [7:0] n_val = 8'd0;

  int checks   = 0;
  int failures = 0;

  stim_t      stim_q[$];
  logic [5:0] exp_q[$];

  contador_ctrl #(.TW(TW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .z     (z),
    .ack   (ack),
    .opc   (opc),
    .req   (req),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Shared down-counter datapath driven by opc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else begin
      case (opc)
        2'd0:    cnt <= 8'd0;
        2'd2:    cnt <= cnt - 8'd1;
        2'd3:    cnt <= n_val;
        default: cnt <= cnt;
      endcase
    end
  end
  assign z = (cnt == 8'd0);

  task automatic push(input logic s, input logic a, input logic k, input logic [5:0] e);
    stim_t st;
    st.s = s;
    st.a = a;
    st.k = k;
    stim_q.push_back(st);
    exp_q.push_back(e);
  endtask

  // Applies the next queued inputs, waits for the edge and returns observed/expected.
  task automatic cycle(output logic [5:0] got, output logic [5:0] expv);
    stim_t st;
    st    = stim_q.pop_front();
    start = st.s;
    abort = st.a;
    ack   = st.k;
    @(negedge clk);
    got  = {opc, req, busy, done, err};
    expv = exp_q.pop_front();
  endtask

  task automatic test_reset;
    logic [5:0] g, e;
    int cyc;
    repeat (2) @(negedge clk);
    checks++;
    if ({opc, req, busy, done, err} !== V_IDLE) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", {opc, req, busy, done, err}, V_IDLE);
    end
    rst = 1'b0;
    n_val = 8'd3;
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    push(0, 0, 0, V_REQ);
    push(0, 0, 0, V_REQ);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_pre cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({opc, req, busy, done, err} !== V_IDLE) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {opc, req, busy, done, err}, V_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    push(0, 0, 0, V_IDLE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_release cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_zero_count;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd0;
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    push(0, 0, 0, V_DONE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL zero_count cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_normal;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd3;
    push(1, 0, 1, V_LOAD);
    push(0, 0, 1, V_CHK);
    for (int it = 0; it < 3; it++) begin
      push(0, 0, 1, V_REQ);
      push((it == 0) ? 1'b1 : 1'b0, 0, 1, V_DEC);
      push(0, 0, 1, V_CHK);
    end
    push(0, 0, 1, V_DONE);
    push(0, 0, 0, V_IDLE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL normal cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_delayed_ack;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd2;
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    for (int it = 0; it < 2; it++) begin
      for (int w = 0; w < 5; w++) push(0, 0, 0, V_REQ);
      push(0, 0, 1, V_DEC);
      push(0, 0, 0, V_CHK);
    end
    push(0, 0, 0, V_DONE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL delayed_ack cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_timeout;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd1;
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    for (int w = 0; w < TMO; w++) push(0, 0, 0, V_REQ);
    push(0, 0, 0, V_ERR);
    push(1, 0, 0, V_ERR);
    push(0, 0, 1, V_ERR);
    push(0, 1, 0, V_IDLE);
    push(0, 0, 0, V_IDLE);
    // Ack on the last permitted REQ cycle still wins over the timeout.
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    for (int w = 0; w < TMO; w++) push(0, 0, 0, V_REQ);
    push(0, 0, 1, V_DEC);
    push(0, 0, 0, V_CHK);
    push(0, 0, 0, V_DONE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL timeout cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_abort;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd2;
    push(1, 0, 0, V_LOAD);
    push(0, 0, 0, V_CHK);
    push(0, 0, 0, V_REQ);
    push(0, 1, 1, V_ABT);
    push(0, 0, 0, V_IDLE);
    push(1, 1, 0, V_IDLE);
    push(0, 1, 0, V_IDLE);
    push(1, 0, 0, V_LOAD);
    push(0, 1, 0, V_ABT);
    push(0, 0, 0, V_IDLE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL abort cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] g, e;
    int cyc;
    n_val = 8'd0;
    push(1, 0, 0, V_LOAD);
    push(1, 0, 0, V_CHK);
    push(1, 0, 0, V_DONE);
    push(1, 0, 0, V_IDLE);
    push(1, 0, 0, V_LOAD);
    push(1, 0, 0, V_CHK);
    push(1, 0, 0, V_DONE);
    push(0, 0, 0, V_IDLE);
    push(0, 0, 0, V_IDLE);
    cyc = 0;
    while (exp_q.size() > 0) begin
      cycle(g, e);
      cyc++;
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%b exp=%b", cyc, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_normal();
    test_delayed_ack();
    test_timeout();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
Control unit that sequences the shared down-counter datapath (clear/hold/decrement/load via 2-bit opc, zero flag z).
- On start, it loads the iteration count into the counter.
- It then runs one req/ack handshake per iteration with a downstream processing unit, decrementing the counter after each acknowledged iteration.
- It pulses done when the counter reaches zero.
- It raises a sticky error if the processing unit fails to acknowledge within a programmable timeout.

Parameters:
TW, 4, width of the ack-timeout counter
TMO, 15, max cycles waited in REQ for ack (0 = timeout disabled; must fit in TW bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a sequence; sampled only in IDLE
abort  input  1  terminate sequence/clear error
z  input  1  counter zero flag (counter register == 0)
ack  input  1  processing unit acknowledges current iteration
opc  output  2  counter command: 0 clear, 1 hold, 2 decrement, 3 load n
req  output  1  iteration request to processing unit
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at sequence completion
err  output  1  high while in ERR (timeout)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, on rst.
- Reset state and outputs:
  - rst=1 forces state IDLE and timeout counter tcnt=0 immediately.
  - Outputs during and after reset: opc=1, req=0, busy=0, done=0, err=0.
- Output decode: all outputs are Moore, decoded from the state register only. No input reaches an output combinationally.
- Counter timing: opc issued in state S takes effect at the clock edge ending S. z therefore reflects that command from the following cycle.
- States (outputs listed as opc/req/busy/done/err):
  - IDLE (1/0/0/0/0): start=1 and abort=0 -> LOAD. Otherwise stay; abort alone has no effect.
  - LOAD (3/0/1/0/0): always -> CHECK.
  - CHECK (1/0/1/0/0): z=1 -> DONE; z=0 -> REQ.
  - REQ (1/1/1/0/0):
    - ack=1 -> DEC.
    - Else if TMO!=0 and tcnt==TMO-1 -> ERR.
    - Else stay, tcnt+1.
  - DEC (2/0/1/0/0): always -> CHECK.
  - DONE (1/0/1/1/0): always -> IDLE.
  - ERR (0/0/1/0/1): stay until abort=1 -> IDLE. The counter is held cleared while in ERR.
  - ABT (0/0/1/0/0): always -> IDLE.
- Abort from active states: abort=1 in LOAD, CHECK, REQ, DEC or DONE -> ABT. Abort has priority over every other transition condition, including ack.
- tcnt rules:
  - Cleared on every entry to REQ and in every state other than REQ.
  - In REQ, ack wins over timeout when both occur in the same cycle.
- Iteration count: a loaded value n gives exactly n req/ack handshakes. n=0 gives zero handshakes and done 3 cycles after start is sampled.
- Latency with ack on the first REQ cycle: done is high in cycle 3+3n after the start edge. Each extra ack-wait cycle adds 1.
- Start handling: start is ignored while busy=1; there is no queuing. start held high through DONE relaunches from IDLE on the next cycle.
- Ack handling: ack outside REQ is ignored. req stays high continuously until ack or timeout; it drops in DEC.
- Reset mid-operation: returns to IDLE with the reset outputs immediately. The counter is reset by the same rst.

Test Plan:
1. Reset: rst pulse mid-REQ (ack low) -> req=0, busy=0, opc=1, err=0 asynchronously; IDLE after release.
2. Zero count: n=0, start 1 cycle -> opc sequence 3,1,1; no req; done=1 exactly 3 cycles after start edge; busy low next cycle.
3. Normal run: n=3, ack tied high -> 3 req pulses; opc shows 2 three times; done at cycle 12; start pulsed while busy is ignored.
4. Delayed ack: n=2, ack 4 cycles after each req -> req held 5 cycles each time; done at cycle 9+8=17.
5. Timeout: TMO=15, n=1, ack never asserted -> ERR after 15 REQ cycles with err=1, opc=0. Abort -> IDLE, err=0. Variant: ack exactly on the 15th REQ cycle -> DEC, no err.
6. Abort and priority:
   - Abort asserted together with ack in REQ -> ABT (opc=0), then IDLE, no done.
   - start and abort together in IDLE -> stays IDLE.
